// File: rtl/frame_buffer_scheduler.sv
// Triple-buffered frame store controller: camera write FIFO, VGA-priority
// memory arbitration and tear-free bank rotation.
module frame_buffer_scheduler #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic                          cam_wr_valid,
    output logic                          cam_wr_ready,
    input  logic [ADDR_W-1:0]             cam_wr_addr,
    input  logic [DATA_W-1:0]             cam_wr_data,
    input  logic                          cam_frame_done,
    input  logic                          vga_rd_req,
    input  logic [ADDR_W-1:0]             vga_rd_addr,
    output logic [DATA_W-1:0]             vga_rd_data,
    output logic                          vga_rd_valid,
    input  logic                          vga_vsync,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W+1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [1:0]                    disp_bank,
    output logic                          frame_drop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 2 + ADDR_W + DATA_W;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [ENT_W-1:0] head;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    logic [1:0] w_bank, r_bank, d_bank;
    logic [1:0] w_next, r_next, d_next;
    logic       new_flag, new_next;
    logic       drop_next;
    logic       vsync_q;
    logic       vsync_fall;

    assign fifo_empty   = (level == '0);
    assign cam_wr_ready = (level != LVL_W'(FIFO_DEPTH));
    assign push         = cam_wr_valid & cam_wr_ready;
    assign pop          = ~vga_rd_req & ~fifo_empty;
    assign head         = fifo_mem[rd_ptr];
    assign fifo_level   = level;
    assign disp_bank    = d_bank;
    assign vsync_fall   = vsync_q & ~vga_vsync;
    assign vga_rd_data  = vga_rd_valid ? mem_rdata : '0;

    // Entry carries the capture bank so it lands correctly after a rotation.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {w_bank, cam_wr_addr, cam_wr_data};
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Vsync is applied before frame_done when both arrive together.
    always_comb begin
        w_next    = w_bank;
        r_next    = r_bank;
        d_next    = d_bank;
        new_next  = new_flag;
        drop_next = 1'b0;
        if (vsync_fall && new_flag) begin
            d_next   = r_bank;
            r_next   = d_bank;
            new_next = 1'b0;
        end
        if (cam_frame_done) begin
            drop_next = new_next;
            w_next    = r_next;
            r_next    = w_bank;
            new_next  = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            w_bank     <= 2'd0;
            r_bank     <= 2'd1;
            d_bank     <= 2'd2;
            new_flag   <= 1'b0;
            frame_drop <= 1'b0;
            vsync_q    <= 1'b1;
        end else begin
            w_bank     <= w_next;
            r_bank     <= r_next;
            d_bank     <= d_next;
            new_flag   <= new_next;
            frame_drop <= drop_next;
            vsync_q    <= vga_vsync;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            vga_rd_valid <= 1'b0;
        end else begin
            vga_rd_valid <= mem_en & ~mem_we;
            if (vga_rd_req) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= {d_bank, vga_rd_addr};
                mem_wdata <= '0;
            end else if (pop) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= head[ENT_W-1:DATA_W];
                mem_wdata <= head[DATA_W-1:0];
            end else begin
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Triple-buffered frame store controller between the camera capture path and the VGA scan-out path.
- Owns the single-port frame memory and arbitrates each cycle between VGA reads (strict priority) and buffered camera writes.
- Rotates bank roles on camera frame completion and VGA vsync so the display never shows a partially written frame.

Parameters:
ADDR_W, 17, pixel address width within one bank (bank holds 2^ADDR_W words, covers 320*240 QVGA)
DATA_W, 12, pixel word width (RGB444)
FIFO_DEPTH, 8, camera write FIFO entries (power of two, >=2)

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cam_wr_valid  in  1  camera pixel write request
cam_wr_ready  out  1  FIFO can accept (= not full)
cam_wr_addr  in  ADDR_W  pixel address within frame
cam_wr_data  in  DATA_W  pixel data
cam_frame_done  in  1  one-cycle pulse after last pixel of a frame is accepted
vga_rd_req  in  1  VGA read request this cycle
vga_rd_addr  in  ADDR_W  pixel address within frame
vga_rd_data  out  DATA_W  read data
vga_rd_valid  out  1  vga_rd_data valid (1 cycle after request)
vga_vsync  in  1  VGA vsync, active low
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W+2  {bank[1:0], pixel addr}
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, 1-cycle latency after mem_en & !mem_we
disp_bank  out  2  bank currently displayed
frame_drop  out  1  one-cycle pulse: a completed frame was overwritten before display
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): W=0, R=1, D=2, new_flag=0, FIFO empty, fifo_level=0, cam_wr_ready=1; all mem_*, vga_rd_valid, vga_rd_data, frame_drop = 0; vsync edge register = 1. Reset mid-operation discards FIFO contents and in-flight reads.
- FIFO push: on cam_wr_valid & cam_wr_ready. Entry = {W at acceptance, addr, data}, so the write lands in its capture bank even after a rotation. cam_wr_ready = (level != FIFO_DEPTH), derived from registered level. Push and pop in the same cycle leave the level unchanged. A push when full is ignored; the source must hold valid.
- Arbitration (combinational on registered FIFO state, memory outputs registered):
  - vga_rd_req=1: read, mem_addr={D, vga_rd_addr}. Next cycle vga_rd_valid=1, vga_rd_data=mem_rdata.
  - else if FIFO non-empty: pop head, mem_we=1, mem_addr={entry bank, entry addr}.
  - else mem_en=0.
  - A VGA request is never stalled. Writes wait for any cycle without a read (blanking).
- D is sampled at read issue. A read issued before a rotation returns old-bank data.
- Vsync event: falling edge of vga_vsync (registered previous value = 1, current = 0).
- Bank rotation (R/W/D always a permutation of {0,1,2}):
  - frame_done only: swap W<->R. If new_flag was 1, pulse frame_drop. Set new_flag=1.
  - vsync only: if new_flag=1, swap D<->R and clear new_flag; else no change.
  - both in the same cycle: apply vsync first, then frame_done. With new_flag=1: D=oldR, R=oldW, W=oldD, new_flag=1, no drop. With new_flag=0: D unchanged, W<->R, new_flag=1.
- disp_bank = D, registered.
- Bank value 3 is never produced. mem_addr upper bits are in 0..2.

Test Plan:
1. Reset, then push 4 writes at addrs 0..3 (data 0xA00..0xA03) with vga_rd_req=0 → four consecutive writes to mem_addr {0,addr}, fifo_level returns to 0.
2. Hold vga_rd_req=1 while pushing 9 writes → writes 1..8 accepted, cam_wr_ready=0 on the 9th with fifo_level=8, no mem_we. Drop vga_rd_req → drain at 1 write/cycle, 9th accepted after the first pop.
3. Read addr 5 of bank 2 preloaded with 0x5A5 → vga_rd_valid=1 with data 0x5A5 exactly 1 cycle later.
4. cam_frame_done, then vsync falling edge → W=1, R=0, then disp_bank=0, new_flag=0. A second vsync with no frame_done → no change.
5. Two cam_frame_done pulses without vsync → frame_drop pulses once, on the second. Bank roles end at W=0, R=1, D=2.
6. Push an entry, then frame_done before it drains (vga_rd_req held) → the entry is written to the old W bank, not the new one. Separately, assert frame_done and vsync in the same cycle with new_flag=1 → D=oldR, R=oldW, W=oldD, no frame_drop.
